ucsbece154_fetchq: RTL and testbench
====================================

UCSBECE154_FETCHQ -- requirements
Module: ucsbece154_fetchq

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, at least 4.
REQ-002 Parameter RESET_PC, default 32'h00010000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_a1_o  output  32  address to instruction memory port 1.
REQ-006 imem_a2_o  output  32  address to instruction memory port 2.
REQ-007 imem_rd1_i  input  32  combinational read data for imem_a1_o.
REQ-008 imem_rd2_i  input  32  combinational read data for imem_a2_o.
REQ-009 redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
REQ-010 redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored.
REQ-011 pop_i  input  2  number of head entries consumed this cycle, 0..2.
REQ-012 valid_o  output  2  bit0: slot0 holds an entry; bit1: slot1 holds an entry.
REQ-013 inst0_o, inst1_o  output  32 each  instructions at queue head and head+1.
REQ-014 pc0_o, pc1_o  output  32 each  PCs of inst0_o and inst1_o.
REQ-015 count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Block SHALL hold fetch PC register pc_q, circular queue of {pc, inst}, head/tail pointers, occupancy count.
REQ-017 imem_a1_o SHALL equal pc_q and imem_a2_o SHALL equal pc_q+4, both combinational, every cycle.
REQ-018 Effective pop SHALL be min(pop_i, count); pop_i beyond occupancy is clamped, never underflows.
REQ-019 free = DEPTH - count + effective pop, evaluated same cycle.
REQ-020 Push count SHALL be 2 if free>=2, 1 if free==1, 0 if free==0.
REQ-021 Push 2 writes {pc_q, imem_rd1_i} at tail, {pc_q+4, imem_rd2_i} at tail+1; push 1 writes only the first.
REQ-022 On a non-redirect edge: pc_q += 4*push; tail += push; head += effective pop; count += push - effective pop.
REQ-023 Pointers SHALL wrap modulo DEPTH; entries written at wrap boundary SHALL be ordered correctly.
REQ-024 Simultaneous pop and push in one cycle SHALL both take effect; full queue with pop 2 SHALL accept push 2.
REQ-025 valid_o[0] = (count>=1), valid_o[1] = (count>=2); inst/pc outputs SHALL read head and head+1 combinationally.
REQ-026 Outputs for slots not flagged valid are don't-care; bench SHALL NOT check them.
REQ-027 redirect_i high at an edge: count<=0, head<=tail<=0, pc_q<={redirect_pc_i[31:2],2'b00}; no push, pop ignored.
REQ-028 Fetch on cycle after redirect SHALL present the new PC on imem_a1_o with no bubble beyond that edge.
REQ-029 Data already written SHALL NOT be overwritten while valid; count SHALL never exceed DEPTH.
REQ-030 Queue contents SHALL be strictly in program order; pc1_o SHALL equal pc0_o+4 unless a redirect intervened (it cannot, flush clears).

Reset
REQ-031 reset high SHALL immediately (asynchronously) set pc_q=RESET_PC, head=tail=0, count=0, valid_o=2'b00, count_o=0.
REQ-032 reset asserted mid-operation SHALL discard all queued entries; redirect_i and pop_i ignored while reset high.
REQ-033 First edge after reset release SHALL push 2 entries at RESET_PC and RESET_PC+4.
REQ-034 Queue storage need not be reset; only control state is.

Verification
REQ-035 Reset release, pop_i=0 for 5 edges, DEPTH=8 -> count_o 2,4,6,8,8; imem_a1_o stuck at 32'h00010020 after full.
REQ-036 Full queue, pop_i=2 one cycle -> count_o stays 8, pc0_o advances by 8, pc_q advances by 8.
REQ-037 count=7, pop_i=0 -> push 1, count_o=8, pc_q advances by 4 only.
REQ-038 count=1, pop_i=2 -> effective pop 1, count_o=2 next (push 2), no underflow.
REQ-039 redirect_i=1, redirect_pc_i=32'h00010047, with pop_i=2 -> next cycle count_o=0, valid_o=0, imem_a1_o=32'h00010044; following edge count_o=2, pc0_o=32'h00010044.
REQ-040 Continuous pop_i=2 for 20 cycles -> pc0_o increments by 8 each cycle across pointer wrap, inst0_o matches memory image word for pc0_o.

Source files
------------

// File: rtl/ucsbece154_fetchq.sv
// Two-wide instruction fetch queue: fetches pc_q/pc_q+4 each cycle into a circular
// buffer of {pc, inst}, exposes the two oldest entries, and flushes on redirect.
module ucsbece154_fetchq #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h00010000
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [31:0]                imem_a1_o,
   output logic [31:0]                imem_a2_o,
   input  logic [31:0]                imem_rd1_i,
   input  logic [31:0]                imem_rd2_i,
   input  logic                       redirect_i,
   input  logic [31:0]                redirect_pc_i,
   input  logic [1:0]                 pop_i,
   output logic [1:0]                 valid_o,
   output logic [31:0]                inst0_o,
   output logic [31:0]                inst1_o,
   output logic [31:0]                pc0_o,
   output logic [31:0]                pc1_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   pc_q;
   logic [AW-1:0] head, tail, head1, tail1;
   logic [CW-1:0] count;
   logic [31:0]   q_pc   [DEPTH];
   logic [31:0]   q_inst [DEPTH];

   logic [1:0]    pop_sat, eff_pop, push;
   logic [CW:0]   free;

   assign head1 = head + AW'(1);
   assign tail1 = tail + AW'(1);

   assign imem_a1_o = pc_q;
   assign imem_a2_o = pc_q + 32'd4;

   // pop_i of 3 is outside the legal range; treat it as 2
   always_comb begin
      pop_sat = (pop_i == 2'd3) ? 2'd2 : pop_i;
      eff_pop = pop_sat;
      if ({{(CW-2){1'b0}}, pop_sat} > count) eff_pop = count[1:0];
      free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(eff_pop);
      push = 2'd0;
      if (free >= (CW+1)'(2))      push = 2'd2;
      else if (free == (CW+1)'(1)) push = 2'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect_i) begin
         pc_q  <= {redirect_pc_i[31:2], 2'b00};
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         pc_q  <= pc_q + {28'd0, push, 2'b00};
         tail  <= tail + AW'(push);
         head  <= head + AW'(eff_pop);
         count <= count + CW'(push) - CW'(eff_pop);
      end
   end

   // Storage is data only; slots being popped this cycle may be reused by the push
   always_ff @(posedge clk) begin
      if (!reset && !redirect_i) begin
         if (push != 2'd0) begin
            q_pc[tail]   <= pc_q;
            q_inst[tail] <= imem_rd1_i;
         end
         if (push == 2'd2) begin
            q_pc[tail1]   <= pc_q + 32'd4;
            q_inst[tail1] <= imem_rd2_i;
         end
      end
   end

   assign valid_o = {count >= CW'(2), count >= CW'(1)};
   assign inst0_o = q_inst[head];
   assign inst1_o = q_inst[head1];
   assign pc0_o   = q_pc[head];
   assign pc1_o   = q_pc[head1];
   assign count_o = count;

endmodule

// File: tb/tb_ucsbece154_fetchq.sv
// Bench for ucsbece154_fetchq: directed scenarios with literal expectations, then
// randomized pop/redirect/reset traffic checked every cycle against a queue model.
module tb_ucsbece154_fetchq;

   localparam int          DEPTH    = 8;
   localparam logic [31:0] RESET_PC = 32'h00010000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_a1_o, imem_a2_o, imem_rd1_i, imem_rd2_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [1:0]  pop_i;
   logic [1:0]  valid_o;
   logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
   logic [3:0]  count_o;

   int checks = 0;
   int errors = 0;

   // Model state: fetch PC and the ordered list of queued PCs
   logic [31:0] m_pc;
   logic [31:0] m_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] img(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   assign imem_rd1_i = img(imem_a1_o);
   assign imem_rd2_i = img(imem_a2_o);

   ucsbece154_fetchq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_a1_o(imem_a1_o), .imem_a2_o(imem_a2_o),
      .imem_rd1_i(imem_rd1_i), .imem_rd2_i(imem_rd2_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .pop_i(pop_i),
      .valid_o(valid_o), .inst0_o(inst0_o), .inst1_o(inst1_o),
      .pc0_o(pc0_o), .pc1_o(pc1_o), .count_o(count_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC;
      m_q.delete();
   endtask

   // One clock edge of the queue as described by its rules
   task automatic model_edge();
      int ep, push;
      if (reset) begin
         model_reset();
      end else if (redirect_i) begin
         m_q.delete();
         m_pc = {redirect_pc_i[31:2], 2'b00};
      end else begin
         ep = (int'(pop_i) < m_q.size()) ? int'(pop_i) : m_q.size();
         repeat (ep) void'(m_q.pop_front());
         push = DEPTH - m_q.size();
         if (push > 2) push = 2;
         for (int i = 0; i < push; i++) m_q.push_back(m_pc + 32'(4*i));
         m_pc = m_pc + 32'(4*push);
      end
   endtask

   task automatic check_model();
      int n;
      n = m_q.size();
      chk("count", 32'(count_o), 32'(n));
      chk("valid", 32'(valid_o), (n >= 2) ? 32'd3 : (n == 1) ? 32'd1 : 32'd0);
      chk("imem_a1", imem_a1_o, m_pc);
      chk("imem_a2", imem_a2_o, m_pc + 32'd4);
      if (n >= 1) begin
         chk("pc0", pc0_o, m_q[0]);
         chk("inst0", inst0_o, img(m_q[0]));
      end
      if (n >= 2) begin
         chk("pc1", pc1_o, m_q[1]);
         chk("inst1", inst1_o, img(m_q[1]));
      end
   endtask

   // Drive inputs, take one edge, then compare away from the edge
   task automatic cyc(input logic [1:0] pop, input logic redir, input logic [31:0] rpc);
      pop_i = pop;
      redirect_i = redir;
      redirect_pc_i = rpc;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   initial begin
      logic [31:0] prev;
      int          r;
      reset = 1'b1;
      redirect_i = 1'b0;
      redirect_pc_i = '0;
      pop_i = 2'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check_model();
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_a1", imem_a1_o, 32'h00010000);
      reset = 1'b0;

      // Fill from reset with no pops
      cyc(2'd0, 1'b0, '0); chk("fill1", 32'(count_o), 32'd2);
      chk("fill1_pc0", pc0_o, 32'h00010000);
      chk("fill1_pc1", pc1_o, 32'h00010004);
      cyc(2'd0, 1'b0, '0); chk("fill2", 32'(count_o), 32'd4);
      cyc(2'd0, 1'b0, '0); chk("fill3", 32'(count_o), 32'd6);
      cyc(2'd0, 1'b0, '0); chk("fill4", 32'(count_o), 32'd8);
      cyc(2'd0, 1'b0, '0); chk("fill5", 32'(count_o), 32'd8);
      chk("full_a1", imem_a1_o, 32'h00010020);

      // Full queue, pop 2 and push 2 together
      cyc(2'd2, 1'b0, '0);
      chk("fullpop_count", 32'(count_o), 32'd8);
      chk("fullpop_pc0", pc0_o, 32'h00010008);
      chk("fullpop_a1", imem_a1_o, 32'h00010028);

      // Redirect with pop ignored, low PC bits dropped
      cyc(2'd2, 1'b1, 32'h00010047);
      chk("redir_count", 32'(count_o), 32'd0);
      chk("redir_valid", 32'(valid_o), 32'd0);
      chk("redir_a1", imem_a1_o, 32'h00010044);
      // Empty queue with pop 2 must not underflow
      cyc(2'd2, 1'b0, '0);
      chk("redir_next_count", 32'(count_o), 32'd2);
      chk("redir_next_pc0", pc0_o, 32'h00010044);
      cyc(2'd0, 1'b0, '0);
      cyc(2'd0, 1'b0, '0);
      cyc(2'd1, 1'b0, '0);
      chk("odd_count", 32'(count_o), 32'd7);
      chk("odd_a1", imem_a1_o, 32'h00010064);
      cyc(2'd0, 1'b0, '0);
      chk("push1_count", 32'(count_o), 32'd8);
      chk("push1_a1", imem_a1_o, 32'h00010068);

      // Steady-state pop 2 across many pointer wraps
      for (int i = 0; i < 20; i++) begin
         prev = pc0_o;
         cyc(2'd2, 1'b0, '0);
         chk("stream_pc0", pc0_o, prev + 32'd8);
         chk("stream_inst0", inst0_o, img(prev + 32'd8));
      end

      // Asynchronous reset mid-cycle
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("async_count", 32'(count_o), 32'd0);
      chk("async_valid", 32'(valid_o), 32'd0);
      chk("async_a1", imem_a1_o, 32'h00010000);
      cyc(2'd2, 1'b1, 32'h12345678);
      reset = 1'b0;
      cyc(2'd0, 1'b0, '0);
      chk("post_rst_pc0", pc0_o, 32'h00010000);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if (reset) begin
            reset = 1'b0;
            cyc(2'($urandom_range(0, 2)), 1'b0, '0);
         end else begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
               #1 reset = 1'b1;
               #1;
               model_reset();
               check_model();
               cyc(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
               cyc(2'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0), $urandom);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
